// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer slice.
// Stack protection is selected by PC_SEQUENCER_STACK_GUARD_EN in the users of this package.
package pc_sequencer_pkg;

  localparam int PC_W   = 10;
  localparam int IR_W   = 22;
  localparam int BSR_HI = 9;
  localparam int BSR_LO = 0;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. PC_SEQUENCER_STACK_GUARD_EN blocks push-on-full/pop-on-empty and
// raises sticky ovf/unf; without it the pointer wraps and the count saturates.
module ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int W     = PC_W,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          unf
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[wp - PW'(1)];

`ifdef PC_SEQUENCER_STACK_GUARD_EN
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && full)  ovf <= 1'b1;
      if (pop && empty)  unf <= 1'b1;
    end
  end
`else
  assign do_push = push;
  assign do_pop  = pop;
  assign ovf     = 1'b0;
  assign unf     = 1'b0;
`endif

  // wp points at the next free slot; when full it points at the oldest entry,
  // so an unguarded push on full overwrites the oldest return address.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      count <= '0;
    end else if (do_push) begin
      wp <= wp + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (do_pop) begin
      wp <= wp - PW'(1);
      if (!empty) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Two-state fetch/execute program-counter sequencer with subroutine call/return stack.
// PC_SEQUENCER_STACK_GUARD_EN turns blocked bsr/ret into plain PC+1 instructions.
module pc_sequencer #(
  parameter int  PC_W        = pc_sequencer_pkg::PC_W,
  parameter int  STACK_DEPTH = 4,
  localparam int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          HOLD,
  input  logic [pc_sequencer_pkg::IR_W-1:0] IR_code,
  input  logic                          bsr_det,
  input  logic                          ret_det,
  output logic [PC_W-1:0]               PC,
  output logic                          ir_load,
  output logic [SP_W-1:0]               sp,
  output logic                          stack_ovf,
  output logic                          stack_unf
);
  import pc_sequencer_pkg::*;

  state_t          state;
  state_t          state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] ret_addr;
  logic            ir_load_nx;
  logic            push;
  logic            pop;
  logic            push_block;
  logic            pop_block;
  logic            unused_ir;

  assign pc_inc    = PC + PC_W'(1);
  assign target    = IR_code[BSR_LO +: PC_W];
  assign unused_ir = ^IR_code[IR_W-1:BSR_LO+PC_W];

`ifdef PC_SEQUENCER_STACK_GUARD_EN
  assign push_block = (sp == SP_W'(STACK_DEPTH));
  assign pop_block  = (sp == '0);
`else
  assign push_block = 1'b0;
  assign pop_block  = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    pc_nx      = PC;
    ir_load_nx = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (!HOLD) begin
      case (state)
        FETCH: begin
          ir_load_nx = 1'b1;
          state_nx   = EXEC;
        end
        EXEC: begin
          state_nx = FETCH;
          pc_nx    = pc_inc;
          if (ret_det) begin
            if (!pop_block) begin
              pop   = 1'b1;
              pc_nx = ret_addr;
            end
          end else if (bsr_det) begin
            if (!push_block) begin
              push  = 1'b1;
              pc_nx = target;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= FETCH;
      PC      <= '0;
      ir_load <= 1'b0;
    end else begin
      state   <= state_nx;
      PC      <= pc_nx;
      ir_load <= ir_load_nx;
    end
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (CLK),
    .reset (RESET),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .count (sp),
    .ovf   (stack_ovf),
    .unf   (stack_unf)
  );

endmodule
